apb_regfile_slave: RTL and testbench

APB completer that terminates the transfers issued by the bridge's APB master. It implements a bank of 32-bit registers with per-byte write strobes, configurable wait states and error reporting. Read/write registers drive fabric-side outputs. Read-only registers return fabric-side status inputs. It sits on one PSELx line of the APB side of the AXI4-Lite-to-APB bridge.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_byte_merge.sv | 21 ++
 rtl/apb_regfile_slave.sv | 151 +++++++++++++++
 tb/tb_apb_regfile_slave.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM encoding and address decode helper.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // Word index of a byte address; only the low byte of PADDR is decoded.
    function automatic logic [5:0] reg_index(input logic [APB_ADDR_W-1:0] addr);
        return addr[7:2];
    endfunction

endpackage

// File: rtl/apb_byte_merge.sv
// Combinational byte-lane merge: lanes with strb set take wdata, the rest keep old_data.
module apb_byte_merge
    import apb_pkg::*;
(
    input  logic [APB_DATA_W-1:0] old_data,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [APB_STRB_W-1:0] strb,
    output logic [APB_DATA_W-1:0] new_data
);

    always_comb begin
        // NOTE: assigning a full default first keeps this block free of inferred latches.
        new_data = old_data;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) begin
                new_data[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with a bank of 32-bit registers, byte strobes, wait states and
// error reporting; read-only registers return fabric status inputs.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [63:0] RO_MASK     = 64'h0
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [APB_ADDR_W-1:0]    PADDR,
    input  logic [APB_DATA_W-1:0]    PWDATA,
    input  logic [APB_STRB_W-1:0]    PSTRB,
    input  logic [2:0]               PPROT,
    output logic                     PREADY,
    output logic [APB_DATA_W-1:0]    PRDATA,
    output logic                     PSLVERR,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse,
    input  logic [32*NUM_REGS-1:0]   hw_status
);

    apb_state_e state, state_d;

    logic [3:0]            wait_cnt;
    logic [5:0]            idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    logic                  setup;
    logic                  access;
    logic                  complete;
    logic                  do_write;
    logic [5:0]            setup_idx;
    logic                  setup_err;
    logic [APB_DATA_W-1:0] sel_reg;
    logic [APB_DATA_W-1:0] sel_status;
    logic [APB_DATA_W-1:0] merged;

    // Upper address bits and protection are accepted but not decoded.
    logic unused_ok;
    assign unused_ok = ^{PADDR[31:8], PPROT};

    assign setup     = (state == ST_IDLE) && PSEL && !PENABLE;
    assign access    = (state == ST_ACCESS) && PSEL && PENABLE;
    assign complete  = access && (wait_cnt == 4'd0);
    assign do_write  = complete && write_q && !err_q;
    assign setup_idx = reg_index(PADDR);
    assign setup_err = (PADDR[1:0] != 2'b00)
                    || (32'(setup_idx) >= 32'(NUM_REGS))
                    || (PWRITE && RO_MASK[setup_idx]);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL || complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= 4'd0;
            idx_q    <= 6'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (setup) begin
            wait_cnt <= 4'(WAIT_CYCLES);
            idx_q    <= setup_idx;
            write_q  <= PWRITE;
            err_q    <= setup_err;
        end else if (access && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Mux-based select tolerates captured indices beyond NUM_REGS (errored accesses).
    always_comb begin
        sel_reg    = '0;
        sel_status = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 6'(i)) begin
                sel_reg    = regs[i];
                sel_status = hw_status[32*i +: 32];
            end
        end
    end

    apb_byte_merge u_merge (
        .old_data (sel_reg),
        .wdata    (PWDATA),
        .strb     (PSTRB),
        .new_data (merged)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: the bank is plain flops with a defined reset value, so it is cleared here rather than left as RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write && (idx_q == 6'(i))) begin
                    regs[i]     <= merged;
                    wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[32*g +: 32] = regs[g];
    end

    assign PREADY  = complete;
    assign PSLVERR = complete && err_q;

    always_comb begin
        PRDATA = '0;
        if (complete && !write_q && !err_q) begin
            PRDATA = RO_MASK[idx_q] ? sel_status : sel_reg;
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: a zero-wait instance with register 0
// read-only and a three-wait-state instance, checked through a response scoreboard.
module tb_apb_regfile_slave;

    localparam int NR = 16;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic            psel0, psel3;
    logic            PENABLE, PWRITE;
    logic [31:0]     PADDR, PWDATA;
    logic [3:0]      PSTRB;
    logic [2:0]      PPROT;

    logic            pready0, pslverr0, pready3, pslverr3;
    logic [31:0]     prdata0, prdata3;
    logic [32*NR-1:0] reg_q0, reg_q3, hw_status0, hw_status3;
    logic [NR-1:0]   wr_pulse0, wr_pulse3;

    exp_t            sb[$];
    logic [31:0]     model [2][NR];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_regfile_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0), .RO_MASK(64'h1)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
        .reg_q(reg_q0), .wr_pulse(wr_pulse0), .hw_status(hw_status0)
    );

    apb_regfile_slave #(.NUM_REGS(NR), .WAIT_CYCLES(3), .RO_MASK(64'h0)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3),
        .reg_q(reg_q3), .wr_pulse(wr_pulse3), .hw_status(hw_status3)
    );

    function automatic logic cur_pready(input int w);
        return (w == 0) ? pready0 : pready3;
    endfunction

    function automatic logic cur_pslverr(input int w);
        return (w == 0) ? pslverr0 : pslverr3;
    endfunction

    function automatic logic [31:0] cur_prdata(input int w);
        return (w == 0) ? prdata0 : prdata3;
    endfunction

    function automatic logic [31:0] cur_pulse(input int w);
        return (w == 0) ? 32'(wr_pulse0) : 32'(wr_pulse3);
    endfunction

    function automatic logic [31:0] cur_reg(input int w, input int i);
        return (w == 0) ? reg_q0[32*i +: 32] : reg_q3[32*i +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input int w, input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s reg_q[%0d]", tag, i), cur_reg(w, i), model[(w == 0) ? 0 : 1][i]);
        end
    endtask

    task automatic idle();
        psel0   = 1'b0;
        psel3   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Drives one transfer from a negedge; returns at the negedge after the completing edge
    // with the bus still asserted, so a following call forms a back-to-back transfer.
    task automatic xfer(input int w, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input bit exp_err, input string tag);
        exp_t        e;
        int          waits;
        int          m;
        int          idx;
        logic [31:0] exp_pulse;
        m       = (w == 0) ? 0 : 1;
        e.tag   = tag;
        e.rdata = wr ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.waits = (w == 0) ? 0 : 3;
        sb.push_back(e);

        psel0   = (w == 0);
        psel3   = (w != 0);
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        @(posedge PCLK);
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits   = 0;
        #1;
        while (!cur_pready(w) && waits < 20) begin
            check({tag, " prdata in wait"}, cur_prdata(w), 32'h0);
            waits++;
            @(negedge PCLK);
            #1;
        end

        e = sb.pop_front();
        check({e.tag, " pready"}, 32'(cur_pready(w)), 32'h1);
        check({e.tag, " wait cycles"}, 32'(waits), 32'(e.waits));
        check({e.tag, " prdata"}, cur_prdata(w), e.rdata);
        check({e.tag, " pslverr"}, 32'(cur_pslverr(w)), 32'(e.err));

        exp_pulse = 32'h0;
        idx       = int'(addr[7:2]);
        if (wr && !exp_err) begin
            exp_pulse = 32'h1 << idx;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[m][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(posedge PCLK);
        @(negedge PCLK);
        check({tag, " wr_pulse"}, cur_pulse(w), exp_pulse);
        check_regs(w, tag);
    endtask

    initial begin
        int start;
        int waits;
        PRESETn    = 1'b0;
        psel0      = 1'b0;
        psel3      = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;
        PSTRB      = '0;
        PPROT      = 3'b010;
        hw_status0 = '0;
        hw_status0[31:0]  = 32'h1234_5678;
        hw_status0[63:32] = 32'hFFFF_0000;
        hw_status3 = {NR{32'hA5A5_A5A5}};
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NR; i++) model[m][i] = 32'h0;

        // Reset state
        @(negedge PCLK);
        @(negedge PCLK);
        check("reset pready", 32'(pready0), 32'h0);
        check("reset prdata", prdata0, 32'h0);
        check("reset pslverr", 32'(pslverr0), 32'h0);
        check("reset wr_pulse", 32'(wr_pulse0), 32'h0);
        check_regs(0, "reset");
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Zero-wait write then read
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr 0x08");
        idle();
        check("wr_pulse one cycle", 32'(wr_pulse0), 32'h0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd 0x08");
        idle();

        // Byte strobes
        xfer(0, 1'b1, 32'h04, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "wr 0x04 full");
        xfer(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "wr 0x04 strb");
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "rd 0x04 merged");
        xfer(0, 1'b1, 32'h14, 32'h7777_7777, 4'h0, 32'h0, 1'b0, "wr 0x14 no strb");
        idle();

        // Errors and read-only register
        xfer(0, 1'b1, 32'h40, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, "wr 0x40 range");
        xfer(0, 1'b1, 32'h06, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, "wr 0x06 misaligned");
        xfer(0, 1'b1, 32'h00, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, "wr ro reg0");
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, "rd 0x40 range");
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "rd ro reg0");
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "rd rw reg1");
        idle();

        // Back-to-back write then read, no idle gap
        start = cyc;
        xfer(0, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "b2b wr 0x0C");
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "b2b rd 0x0C");
        check("b2b cycle count", 32'(cyc - start), 32'd4);
        idle();

        // Wait states
        xfer(3, 1'b1, 32'h04, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, "ws wr 0x04");
        xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, "ws rd 0x04");
        idle();

        // Access phase without a setup phase: completer must not respond
        $display("note: issuing access phase without setup on dut0 (protocol violation)");
        psel0   = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h08;
        PWDATA  = 32'h0;
        PSTRB   = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("no-setup pready %0d", k), 32'(pready0), 32'h0);
            @(negedge PCLK);
        end
        idle();
        check_regs(0, "no-setup");

        // Abort during a wait state
        psel3   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h04;
        PWDATA  = 32'h0;
        PSTRB   = 4'hF;
        @(posedge PCLK);
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("abort pready in wait", 32'(pready3), 32'h0);
        @(negedge PCLK);
        psel3   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort pready", 32'(pready3), 32'h0);
        check("abort wr_pulse", 32'(wr_pulse3), 32'h0);
        check_regs(3, "abort");
        @(negedge PCLK);
        check("abort wr_pulse later", 32'(wr_pulse3), 32'h0);
        xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, "post-abort rd");
        idle();

        // Asynchronous reset in the PREADY cycle of a read
        psel3   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h04;
        @(posedge PCLK);
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits   = 0;
        #1;
        while (!pready3 && waits < 20) begin
            waits++;
            @(negedge PCLK);
            #1;
        end
        check("pre-reset pready", 32'(pready3), 32'h1);
        check("pre-reset prdata", prdata3, 32'h55AA_55AA);
        #2;
        PRESETn = 1'b0;
        #1;
        check("async reset pready", 32'(pready3), 32'h0);
        check("async reset prdata", prdata3, 32'h0);
        check("async reset pslverr", 32'(pslverr3), 32'h0);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NR; i++) model[m][i] = 32'h0;
        check_regs(3, "async reset");
        check_regs(0, "async reset");
        psel3   = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
